// File: rtl/chimp_round_ctrl.sv
// Chimp memory-game sequencer: owns the tile board, places numbers 1..count, checks click order, tracks level and strikes.
// Start/click effects land on the next clk edge; no backpressure, every pulse is either consumed or ignored.
module chimp_round_ctrl #(
    parameter int         NUM_TILES   = 40,
    parameter int         START_COUNT = 4,
    parameter int         MAX_COUNT   = 31,
    parameter int         MAX_STRIKES = 3,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       iReset,
    input  logic       iKey0,
    input  logic [1:0] iGameMode,
    input  logic       iStart,
    input  logic       iClickValid,
    input  logic [5:0] iClickTile,
    input  logic [5:0] iRdTile,
    output logic [6:0] oTile,
    output logic [2:0] oState,
    output logic [4:0] oCount,
    output logic [4:0] oScore,
    output logic [1:0] oStrikes,
    output logic       oDone,
    output logic       oWin
);
    localparam int         TILE_SLOTS    = 64;
    localparam logic [6:0] NUM_TILES_W   = 7'(NUM_TILES);
    localparam logic [4:0] START_W       = 5'(START_COUNT);
    localparam logic [4:0] MAX_COUNT_W   = 5'(MAX_COUNT);
    localparam logic [1:0] MAX_STRIKES_W = 2'(MAX_STRIKES);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_PLACE     = 3'd2,
        ST_PLAY      = 3'd3,
        ST_LEVEL_UP  = 3'd4,
        ST_FAIL      = 3'd5,
        ST_GAME_OVER = 3'd6
    } state_t;

    // Tile entry: [6]=active, [5]=showing, [4:0]=number. Slots at or above
    // NUM_TILES are held at zero so the full 6-bit address space reads cleanly.
    logic [6:0] tiles_q [TILE_SLOTS];
    logic [6:0] tiles_d [TILE_SLOTS];

    state_t     state_q, state_d;
    logic [4:0] count_q, count_d;
    logic [4:0] score_q, score_d;
    logic [1:0] strikes_q, strikes_d;
    logic [5:0] expected_q, expected_d;
    logic [5:0] place_k_q, place_k_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic       win_q, win_d;

    logic [5:0] cand;
    logic       cand_free;
    logic [6:0] click_ent;
    logic       click_hit;
    logic       abort;

    assign cand      = lfsr_q[5:0];
    assign cand_free = ({1'b0, cand} < NUM_TILES_W) && !tiles_q[cand][6];
    assign click_ent = tiles_q[iClickTile];
    assign click_hit = iClickValid && ({1'b0, iClickTile} < NUM_TILES_W) && click_ent[6];
    assign abort     = iKey0 || (iGameMode != 2'b10);

    always_comb begin
        state_d    = state_q;
        tiles_d    = tiles_q;
        count_d    = count_q;
        score_d    = score_q;
        strikes_d  = strikes_q;
        expected_d = expected_q;
        place_k_d  = place_k_q;
        win_d      = win_q;
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        case (state_q)
            ST_IDLE: begin
                if (iStart && iGameMode == 2'b10) begin
                    count_d   = START_W;
                    score_d   = '0;
                    strikes_d = '0;
                    win_d     = 1'b0;
                    state_d   = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                for (int i = 0; i < TILE_SLOTS; i++) tiles_d[i] = '0;
                place_k_d = 6'd1;
                state_d   = ST_PLACE;
            end
            ST_PLACE: begin
                if (cand_free) begin
                    tiles_d[cand] = {1'b1, 1'b1, place_k_q[4:0]};
                    place_k_d     = place_k_q + 6'd1;
                    if (place_k_q == {1'b0, count_q}) begin
                        expected_d = 6'd1;
                        state_d    = ST_PLAY;
                    end
                end
            end
            ST_PLAY: begin
                if (click_hit) begin
                    if ({1'b0, click_ent[4:0]} == expected_q) begin
                        // The first correct click hides every number on the board.
                        if (expected_q == 6'd1) begin
                            for (int i = 0; i < TILE_SLOTS; i++) tiles_d[i][5] = 1'b0;
                        end
                        tiles_d[iClickTile] = '0;
                        expected_d          = expected_q + 6'd1;
                        if (expected_q == {1'b0, count_q}) state_d = ST_LEVEL_UP;
                    end else begin
                        if (strikes_q != MAX_STRIKES_W) strikes_d = strikes_q + 2'd1;
                        if ({1'b0, strikes_q} + 3'd1 == {1'b0, MAX_STRIKES_W}) state_d = ST_GAME_OVER;
                        else                                                   state_d = ST_FAIL;
                    end
                end
            end
            ST_LEVEL_UP: begin
                score_d = count_q;
                if (count_q >= MAX_COUNT_W) begin
                    win_d   = 1'b1;
                    state_d = ST_GAME_OVER;
                end else begin
                    count_d = count_q + 5'd1;
                    state_d = ST_CLEAR;
                end
            end
            ST_FAIL: begin
                state_d = ST_CLEAR;
            end
            ST_GAME_OVER: begin
                if (iStart) begin
                    count_d   = START_W;
                    score_d   = '0;
                    strikes_d = '0;
                    win_d     = 1'b0;
                    state_d   = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort mirrors reset except that the LFSR keeps free-running.
        if (abort) begin
            for (int i = 0; i < TILE_SLOTS; i++) tiles_d[i] = '0;
            state_d    = ST_IDLE;
            count_d    = START_W;
            score_d    = '0;
            strikes_d  = '0;
            expected_d = '0;
            place_k_d  = '0;
            win_d      = 1'b0;
        end

        for (int i = NUM_TILES; i < TILE_SLOTS; i++) tiles_d[i] = '0;
    end

    always_ff @(posedge clk or negedge iReset) begin
        if (!iReset) begin
            for (int i = 0; i < TILE_SLOTS; i++) tiles_q[i] <= '0;
            state_q    <= ST_IDLE;
            count_q    <= START_W;
            score_q    <= '0;
            strikes_q  <= '0;
            expected_q <= '0;
            place_k_q  <= '0;
            lfsr_q     <= LFSR_SEED;
            win_q      <= 1'b0;
        end else begin
            tiles_q    <= tiles_d;
            state_q    <= state_d;
            count_q    <= count_d;
            score_q    <= score_d;
            strikes_q  <= strikes_d;
            expected_q <= expected_d;
            place_k_q  <= place_k_d;
            lfsr_q     <= lfsr_d;
            win_q      <= win_d;
        end
    end

    assign oTile    = tiles_q[iRdTile];
    assign oState   = state_q;
    assign oCount   = count_q;
    assign oScore   = score_q;
    assign oStrikes = strikes_q;
    assign oDone    = (state_q == ST_GAME_OVER);
    assign oWin     = win_q;

endmodule

// File: tb/tb_chimp_round_ctrl.sv
// Scoreboard bench for chimp_round_ctrl: stimulus pushes expected outputs from a game-level model,
// a monitor scans the board every cycle on the falling edge and pops/compares due expectations.
module tb_chimp_round_ctrl;
    localparam int S_IDLE = 0, S_CLEAR = 1, S_PLACE = 2, S_PLAY = 3;
    localparam int S_LEVELUP = 4, S_FAIL = 5, S_OVER = 6;
    localparam int K_STATE = 0, K_COUNT = 1, K_SCORE = 2, K_STRIKES = 3;
    localparam int K_DONE = 4, K_WIN = 5, K_TILE = 6, K_LAYOUT = 7;
    localparam int NT = 40;

    logic       clk = 1'b0;
    logic       iReset;
    logic       iKey0;
    logic [1:0] iGameMode;
    logic       iStart;
    logic       iClickValid;
    logic [5:0] iClickTile;
    logic [5:0] rd_tile = '0;
    logic [6:0] oTile;
    logic [2:0] oState;
    logic [4:0] oCount;
    logic [4:0] oScore;
    logic [1:0] oStrikes;
    logic       oDone;
    logic       oWin;

    chimp_round_ctrl dut (
        .clk        (clk),
        .iReset     (iReset),
        .iKey0      (iKey0),
        .iGameMode  (iGameMode),
        .iStart     (iStart),
        .iClickValid(iClickValid),
        .iClickTile (iClickTile),
        .iRdTile    (rd_tile),
        .oTile      (oTile),
        .oState     (oState),
        .oCount     (oCount),
        .oScore     (oScore),
        .oStrikes   (oStrikes),
        .oDone      (oDone),
        .oWin       (oWin)
    );

    always #100 clk = ~clk;

    typedef struct {
        int due;
        int kind;
        int idx;
        int val;
    } exp_t;

    exp_t       exp_q[$];
    logic [6:0] snap [64];
    int         cyc      = 0;
    int         checks   = 0;
    int         failures = 0;
    event       snap_ev;

    int         mdl_state, mdl_count, mdl_score, mdl_strikes, mdl_win, mdl_expected;
    logic [6:0] mdl_board [64];
    int         tile_of [32];

    function automatic int layout_ok(int n);
        int seen [32];
        int ok = 1;
        int num;
        for (int k = 0; k < 32; k++) seen[k] = 0;
        for (int i = 0; i < 64; i++) begin
            if (snap[i] != 7'd0) begin
                num = int'(snap[i][4:0]);
                if (i >= NT || snap[i][6:5] != 2'b11 || num == 0 || num > n || seen[num] != 0) ok = 0;
                else seen[num] = 1;
            end
        end
        for (int k = 1; k <= n; k++) if (seen[k] == 0) ok = 0;
        return ok;
    endfunction

    task automatic check_item(input exp_t e);
        int    act;
        string nm;
        case (e.kind)
            K_STATE:   begin act = int'(oState);   nm = "state";   end
            K_COUNT:   begin act = int'(oCount);   nm = "count";   end
            K_SCORE:   begin act = int'(oScore);   nm = "score";   end
            K_STRIKES: begin act = int'(oStrikes); nm = "strikes"; end
            K_DONE:    begin act = int'(oDone);    nm = "done";    end
            K_WIN:     begin act = int'(oWin);     nm = "win";     end
            K_TILE:    begin act = int'(snap[e.idx]); nm = $sformatf("tile[%0d]", e.idx); end
            default:   begin act = layout_ok(e.idx);  nm = $sformatf("layout_n%0d", e.idx); end
        endcase
        checks++;
        if (act != e.val) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, e.val);
        end
    endtask

    // Monitor: full board scan through the read port, then compare everything due.
    always begin
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            rd_tile = 6'(i);
            #1;
            snap[i] = oTile;
        end
        cyc++;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) check_item(exp_q.pop_front());
        ->snap_ev;
    end

    task automatic step();
        @(snap_ev);
    endtask

    task automatic push(input int kind, input int idx, input int val);
        exp_t e;
        e.due  = cyc + 1;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic expect_regs();
        push(K_STATE, 0, mdl_state);
        push(K_COUNT, 0, mdl_count);
        push(K_SCORE, 0, mdl_score);
        push(K_STRIKES, 0, mdl_strikes);
        push(K_DONE, 0, (mdl_state == S_OVER) ? 1 : 0);
        push(K_WIN, 0, mdl_win);
    endtask

    task automatic expect_board();
        for (int i = 0; i < 64; i++) push(K_TILE, i, int'(mdl_board[i]));
    endtask

    task automatic model_reset();
        mdl_state    = S_IDLE;
        mdl_count    = 4;
        mdl_score    = 0;
        mdl_strikes  = 0;
        mdl_win      = 0;
        mdl_expected = 0;
        for (int i = 0; i < 64; i++) mdl_board[i] = '0;
    endtask

    task automatic wait_state(input int s, input int budget);
        int waited = 0;
        while (int'(oState) != s && waited < budget) begin
            step();
            waited++;
        end
        checks++;
        if (int'(oState) != s) begin
            failures++;
            $display("FAIL reach_state%0d: state=%0d after %0d cycles, expected %0d", s, oState, waited, s);
        end
    endtask

    task automatic start_game();
        iStart = 1'b1;
        mdl_state   = S_CLEAR;
        mdl_count   = 4;
        mdl_score   = 0;
        mdl_strikes = 0;
        mdl_win     = 0;
        expect_regs();
        step();
        iStart = 1'b0;
        mdl_state = S_PLACE;
        for (int i = 0; i < 64; i++) mdl_board[i] = '0;
        expect_regs();
        expect_board();
        step();
    endtask

    // The layout is the DUT's random choice: validate it against the placement
    // rules, then adopt it as the model board for the click sequence.
    task automatic begin_level(input int n, input int budget);
        wait_state(S_PLAY, budget);
        mdl_state    = S_PLAY;
        mdl_expected = 1;
        for (int k = 0; k < 32; k++) tile_of[k] = 0;
        for (int i = 0; i < 64; i++) begin
            mdl_board[i] = snap[i];
            if (snap[i][6]) tile_of[int'(snap[i][4:0])] = i;
        end
        push(K_LAYOUT, n, 1);
        expect_regs();
        step();
    endtask

    task automatic click(input int t);
        int num;
        iClickValid = 1'b1;
        iClickTile  = 6'(t);
        if (mdl_state == S_PLAY && t < NT && mdl_board[t][6]) begin
            num = int'(mdl_board[t][4:0]);
            if (num == mdl_expected) begin
                if (mdl_expected == 1) for (int i = 0; i < 64; i++) mdl_board[i][5] = 1'b0;
                mdl_board[t] = '0;
                if (num == mdl_count) mdl_state = S_LEVELUP;
                mdl_expected++;
            end else begin
                mdl_strikes = (mdl_strikes < 3) ? mdl_strikes + 1 : 3;
                mdl_state   = (mdl_strikes == 3) ? S_OVER : S_FAIL;
            end
        end
        if (mdl_state == S_PLACE) begin
            push(K_STRIKES, 0, mdl_strikes);
        end else begin
            expect_regs();
            expect_board();
        end
        step();
        iClickValid = 1'b0;
    endtask

    task automatic play_level();
        int n = mdl_count;
        for (int k = 1; k <= n; k++) click(tile_of[k]);
        mdl_score = mdl_count;
        if (mdl_count == 31) begin
            mdl_win   = 1;
            mdl_state = S_OVER;
        end else begin
            mdl_count++;
            mdl_state = S_CLEAR;
        end
        expect_regs();
        step();
    endtask

    task automatic wrong_click(input int num);
        click(tile_of[num]);
        if (mdl_state == S_FAIL) begin
            mdl_state = S_CLEAR;
            expect_regs();
            step();
        end
    endtask

    initial begin
        #(200 * 40000);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        iReset      = 1'b0;
        iKey0       = 1'b0;
        iGameMode   = 2'b10;
        iStart      = 1'b0;
        iClickValid = 1'b0;
        iClickTile  = '0;
        model_reset();

        step();
        expect_regs();
        expect_board();
        step();
        iReset = 1'b1;
        step();

        // Wrong game mode keeps the block parked in IDLE even with a start pulse.
        iGameMode = 2'b01;
        iStart    = 1'b1;
        expect_regs();
        step();
        iStart    = 1'b0;
        iGameMode = 2'b10;
        step();

        // Game 1: first level, ignored clicks, level-up, strike, click during PLACE, abort.
        start_game();
        begin_level(4, 200);
        t = 0;
        for (int i = NT - 1; i >= 0; i--) if (mdl_board[i] == 7'd0) t = i;
        click(t);
        click(45);
        play_level();
        begin_level(5, 600);
        wrong_click(3);
        wait_state(S_PLACE, 10);
        mdl_state = S_PLACE;
        t = 0;
        for (int i = NT - 1; i >= 0; i--) if (snap[i][6]) t = i;
        click(t);
        begin_level(5, 600);
        iKey0 = 1'b1;
        model_reset();
        expect_regs();
        expect_board();
        step();
        iKey0 = 1'b0;
        step();

        // Game 2: three strikes end the game; the frozen board ignores clicks.
        start_game();
        for (int r = 0; r < 3; r++) begin
            begin_level(4, 600);
            wrong_click(2);
        end
        click(tile_of[1]);

        // Game 3: clear every level up to the cap for the win.
        start_game();
        for (int c = 4; c <= 31; c++) begin
            begin_level(c, 600);
            play_level();
        end
        expect_regs();
        step();

        // Restart from the win, then drop reset while placing.
        start_game();
        iReset = 1'b0;
        #1;
        model_reset();
        expect_regs();
        expect_board();
        step();
        iReset = 1'b1;
        expect_regs();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chimp_round_ctrl.md
Name: chimp_round_ctrl

Overview:
- Sequencer for the chimp memory game.
- Owns the tile board: places numbers 1..N on random tiles and hides them after the first correct click.
- Checks click order, counts strikes and advances the level.
- Sits between the input/click decoder and the VGA tile renderer. The renderer reads tile state through a read port that uses the per-tile 7-bit format.

Parameters:
- NUM_TILES, 40, number of board tiles (indices 0..NUM_TILES-1, max 64).
- START_COUNT, 4, numbers placed on the first level.
- MAX_COUNT, 31, highest level count; the 5-bit number field caps it at 31; must be < NUM_TILES.
- MAX_STRIKES, 3, wrong clicks allowed before game over.
- LFSR_SEED, 8'hA5, nonzero reset value of the placement LFSR.

Ports:
- clk  in  1  system clock
- iReset  in  1  asynchronous reset, active-low
- iKey0  in  1  synchronous abort to menu, active-high
- iGameMode  in  2  2'b10 selects chimp; other values hold the block in IDLE
- iStart  in  1  one-cycle pulse, start or restart game
- iClickValid  in  1  one-cycle pulse, a tile was clicked
- iClickTile  in  6  clicked tile index
- iRdTile  in  6  renderer read address
- oTile  out  7  [6]=active, [5]=showing, [4:0]=number for iRdTile; combinational from registers; 0 if iRdTile >= NUM_TILES
- oState  out  3  current FSM state encoding, listed below
- oCount  out  5  numbers in the current level
- oScore  out  5  highest level count completed
- oStrikes  out  2  wrong clicks so far
- oDone  out  1  high in GAME_OVER
- oWin  out  1  high in GAME_OVER if MAX_COUNT was cleared

Behaviour:
- Reset (iReset low, async):
  - All tile entries 0; state IDLE.
  - count=START_COUNT; score, strikes, expected and place index all 0.
  - lfsr=LFSR_SEED; oDone=0, oWin=0.
- iKey0 high, or iGameMode!=2'b10, in any state: next cycle is IDLE with the same clears as reset, except the LFSR keeps running.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every cycle in every state except during reset.
- States and encodings:
  - IDLE=0: on iStart with iGameMode==2'b10, clear count/score/strikes/oWin and go to CLEAR.
  - CLEAR=1: one cycle; all tiles zeroed; k=1; go to PLACE.
  - PLACE=2:
    - Each cycle the candidate tile is lfsr[5:0].
    - If candidate < NUM_TILES and that tile is inactive, write {1,1,k} and increment k. Otherwise write nothing.
    - When k exceeds count (same cycle as the last write completes), go to PLAY with expected=1.
    - Placement always terminates because count < NUM_TILES.
  - PLAY=3: on iClickValid, ignore the click if iClickTile >= NUM_TILES or the tile is inactive. Otherwise:
    - Correct (number==expected): clear that tile's active bit. If expected==1, also clear the showing bit of every tile in the same cycle. Increment expected. If expected==count, go to LEVEL_UP.
    - Wrong (number != expected): increment strikes. Go to GAME_OVER if strikes+1==MAX_STRIKES, else FAIL.
  - LEVEL_UP=4: score=count. If count==MAX_COUNT, set oWin and go to GAME_OVER. Otherwise increment count and go to CLEAR.
  - FAIL=5: one cycle; go to CLEAR with count unchanged, so the same level is replayed with a new layout.
  - GAME_OVER=6: oDone=1; tiles frozen. iStart goes to CLEAR with count=START_COUNT and score, strikes, oWin cleared.
- Clicks are ignored outside PLAY. iStart is ignored outside IDLE and GAME_OVER.
- Click latency: a click sampled at edge t is visible on oTile, oState and oStrikes after edge t.
- Simultaneous events: priority is iKey0, then iStart, then iClickValid.
- Counters saturate: strikes at MAX_STRIKES, count at MAX_COUNT.

Test Plan:
- Reset, then iStart with iGameMode=2'b10 → CLEAR, then PLACE. Exactly 4 tiles have active=1, showing=1 with numbers 1..4, all distinct, all indices < 40; PLAY within 200 cycles.
- In PLAY, click the tile holding 1 → that tile reads 0x00; the other three have showing=0 and active=1. Clicks on 2, 3, 4 → LEVEL_UP, oScore=4, oCount=5, new board with numbers 1..5.
- In PLAY, click the tile holding 3 first → oStrikes=1, FAIL then CLEAR, oCount still 4. Two more wrong clicks on later boards → oStrikes=3, oDone=1, oWin=0, oState=6.
- Click an empty tile, click index 45, and click during PLACE → no change to strikes, tiles or state.
- Pulse iKey0 mid-PLAY, and separately drop iReset mid-PLACE → IDLE, all oTile reads 0, oCount=4. Set iGameMode=2'b01 and pulse iStart → stays in IDLE.
- Force count=31 and complete the level → oScore=31, oWin=1, oDone=1. iStart → oCount=4, oScore=0, oWin=0.
